// File: rtl/core_seq.sv
// Tile sequencer for the systolic core: fetches weights, loads kernels, streams
// activations and drains OFIFO rows into psum SRAM (overwrite or saturating accumulate).
module core_seq #(
  parameter int unsigned ROW     = 8,
  parameter int unsigned COL     = 8,
  parameter int unsigned BW      = 4,
  parameter int unsigned PSUM_BW = 16,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned LEN_W   = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_W-1:0]        cmd_w_base,
  input  logic [ADDR_W-1:0]        cmd_x_base,
  input  logic [ADDR_W-1:0]        cmd_p_base,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     cmd_acc,
  output logic                     xmem_cen,
  output logic [ADDR_W-1:0]        xmem_a,
  output logic                     l0_wr,
  output logic                     load,
  output logic                     execute,
  input  logic                     ofifo_valid,
  input  logic [PSUM_BW*COL-1:0]   ofifo_data,
  output logic                     ofifo_rd,
  output logic                     pmem_cen,
  output logic                     pmem_wen,
  output logic [ADDR_W-1:0]        pmem_a,
  output logic [PSUM_BW*COL-1:0]   pmem_d,
  input  logic [PSUM_BW*COL-1:0]   pmem_q,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DW = PSUM_BW * COL;

  // Step counters share LEN_W bits, so ROW/COL must fit in that range.
  if (BW == 0 || ROW == 0 || COL == 0 || PSUM_BW < 2 ||
      ROW > (1 << LEN_W) || COL > (1 << LEN_W)) begin : g_bad_params
    $error("core_seq: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_W_RD, S_LOAD, S_X_RD, S_DRAIN, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  d_q, d_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [ADDR_W-1:0] x_base_q, x_base_d;
  logic [ADDR_W-1:0] p_base_q, p_base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              acc_q, acc_d;
  logic              l0_wr_q, l0_wr_d;
  logic              x_tail_q, x_tail_d;
  logic [DW-1:0]     acc_sum;

  function automatic logic [PSUM_BW-1:0] sat_add(input logic [PSUM_BW-1:0] a,
                                                 input logic [PSUM_BW-1:0] b);
    logic [PSUM_BW:0]   s;
    logic [PSUM_BW-1:0] r;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    r = s[PSUM_BW-1:0];
    if (s[PSUM_BW] != s[PSUM_BW-1]) begin
      r = s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
    end
    return r;
  endfunction

  // Per-lane signed saturating sum for the read-modify-write path.
  always_comb begin
    acc_sum = '0;
    for (int l = 0; l < int'(COL); l++) begin
      acc_sum[l*PSUM_BW +: PSUM_BW] = sat_add(pmem_q[l*PSUM_BW +: PSUM_BW],
                                              ofifo_data[l*PSUM_BW +: PSUM_BW]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      d_q      <= '0;
      phase_q  <= 1'b0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      len_q    <= '0;
      acc_q    <= 1'b0;
      l0_wr_q  <= 1'b0;
      x_tail_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      phase_q  <= phase_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      p_base_q <= p_base_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      l0_wr_q  <= l0_wr_d;
      x_tail_q <= x_tail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    phase_d   = phase_q;
    w_base_d  = w_base_q;
    x_base_d  = x_base_q;
    p_base_d  = p_base_q;
    len_d     = len_q;
    acc_d     = acc_q;
    l0_wr_d   = 1'b0;
    x_tail_d  = 1'b0;
    cmd_ready = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    xmem_cen  = 1'b1;
    xmem_a    = '0;
    l0_wr     = l0_wr_q;
    load      = 1'b0;
    execute   = x_tail_q;
    ofifo_rd  = 1'b0;
    pmem_cen  = 1'b1;
    pmem_wen  = 1'b1;
    pmem_a    = '0;
    pmem_d    = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_base_d = cmd_w_base;
          x_base_d = cmd_x_base;
          p_base_d = cmd_p_base;
          len_d    = cmd_len;
          acc_d    = cmd_acc;
          cnt_d    = '0;
          d_d      = '0;
          phase_d  = 1'b0;
          state_d  = S_W_RD;
        end
      end
      S_W_RD: begin
        xmem_cen = 1'b0;
        xmem_a   = w_base_q + ADDR_W'(cnt_q);
        l0_wr_d  = 1'b1;
        if (cnt_q == LEN_W'(ROW - 1)) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_LOAD: begin
        load = 1'b1;
        if (cnt_q == LEN_W'(COL - 1)) begin
          cnt_d   = '0;
          state_d = (len_q == '0) ? S_DONE : S_X_RD;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_X_RD: begin
        xmem_cen = 1'b0;
        xmem_a   = x_base_q + ADDR_W'(cnt_q);
        l0_wr_d  = 1'b1;
        x_tail_d = 1'b1;
        execute  = 1'b1;
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        if (d_q == len_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Drain engine: one row per cycle when overwriting, read then write when accumulating.
    if ((state_q == S_X_RD || state_q == S_DRAIN) && d_q != len_q && ofifo_valid) begin
      pmem_cen = 1'b0;
      pmem_a   = p_base_q + ADDR_W'(d_q);
      if (!acc_q) begin
        ofifo_rd = 1'b1;
        pmem_wen = 1'b0;
        pmem_d   = ofifo_data;
        d_d      = d_q + LEN_W'(1);
      end else if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        ofifo_rd = 1'b1;
        pmem_wen = 1'b0;
        pmem_d   = acc_sum;
        d_d      = d_q + LEN_W'(1);
        phase_d  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: a tile-level reference model queues expected SRAM
// traffic, and a negedge monitor pops and compares each strobe the DUT presents.
module tb_core_seq;

  localparam int unsigned ROW     = 8;
  localparam int unsigned COL     = 8;
  localparam int unsigned BW      = 4;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned LEN_W   = 11;
  localparam int unsigned DW      = PSUM_BW * COL;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_w_base = '0;
  logic [ADDR_W-1:0] cmd_x_base = '0;
  logic [ADDR_W-1:0] cmd_p_base = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              cmd_acc = 1'b0;
  logic              xmem_cen;
  logic [ADDR_W-1:0] xmem_a;
  logic              l0_wr, load, execute;
  logic              ofifo_valid = 1'b0;
  logic [DW-1:0]     ofifo_data = '0;
  logic              ofifo_rd;
  logic              pmem_cen, pmem_wen;
  logic [ADDR_W-1:0] pmem_a;
  logic [DW-1:0]     pmem_d;
  logic [DW-1:0]     pmem_q = '0;
  logic              busy, done;

  core_seq #(.ROW(ROW), .COL(COL), .BW(BW), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w_base(cmd_w_base), .cmd_x_base(cmd_x_base), .cmd_p_base(cmd_p_base),
    .cmd_len(cmd_len), .cmd_acc(cmd_acc), .xmem_cen(xmem_cen), .xmem_a(xmem_a),
    .l0_wr(l0_wr), .load(load), .execute(execute), .ofifo_valid(ofifo_valid),
    .ofifo_data(ofifo_data), .ofifo_rd(ofifo_rd), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
    .pmem_a(pmem_a), .pmem_d(pmem_d), .pmem_q(pmem_q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [ADDR_W-1:0] a; logic [DW-1:0] d; } pw_t;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_xa[$];
  logic [ADDR_W-1:0] exp_pr[$];
  pw_t               exp_pw[$];
  logic [DW-1:0]     ofq[$];
  logic [PSUM_BW-1:0] force_lane0[$];
  logic [DW-1:0]     mem     [DEPTH];
  logic [DW-1:0]     ref_mem [DEPTH];

  bit cur_acc = 1'b0;
  int valid_mode = 0;
  bit gate = 1'b0;
  int n_load = 0, n_l0 = 0, n_exec = 0, n_done = 0, n_pop = 0, n_pr = 0;
  bit prev_xrd = 1'b0, prev_rd_valid = 1'b0;
  logic [ADDR_W-1:0] prev_rd_a = '0;
  bit pop_pend = 1'b0, wr_pend = 1'b0, rd_pend = 1'b0;
  logic [ADDR_W-1:0] wr_a = '0, rd_a = '0;
  logic [DW-1:0] wr_d = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected strobe, expected none", name);
  endtask

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Lane-wise signed add clamped to the psum range.
  function automatic logic [DW-1:0] sat_row(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int s, hi, lo;
    hi = (1 << (PSUM_BW - 1)) - 1;
    lo = -(1 << (PSUM_BW - 1));
    r = '0;
    for (int l = 0; l < int'(COL); l++) begin
      s = int'($signed(a[l*PSUM_BW +: PSUM_BW])) + int'($signed(b[l*PSUM_BW +: PSUM_BW]));
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
      r[l*PSUM_BW +: PSUM_BW] = PSUM_BW'(s);
    end
    return r;
  endfunction

  // OFIFO and pmem device models; an offered OFIFO row stays valid until popped.
  initial begin
    bit popped;
    forever begin
      @(posedge clk);
      #1;
      popped = pop_pend && (ofq.size() > 0);
      if (popped) void'(ofq.pop_front());
      if (wr_pend) mem[wr_a] = wr_d;
      if (rd_pend) pmem_q = mem[rd_a];
      pop_pend = 1'b0;
      wr_pend  = 1'b0;
      rd_pend  = 1'b0;
      if (!(ofifo_valid && !popped && ofq.size() > 0)) begin
        case (valid_mode)
          0:       gate = 1'b1;
          1:       gate = !gate;
          default: gate = ($urandom_range(0, 2) != 0);
        endcase
      end
      ofifo_valid = gate && (ofq.size() > 0);
      ofifo_data  = (ofq.size() > 0) ? ofq[0] : '0;
    end
  end

  always @(negedge clk) begin : monitor
    pw_t e;
    if (reset) begin
      pop_pend = 1'b0; wr_pend = 1'b0; rd_pend = 1'b0;
      prev_xrd = 1'b0; prev_rd_valid = 1'b0;
    end else begin
      chk("l0_wr_timing", DW'(l0_wr), DW'(prev_xrd));
      prev_xrd = !xmem_cen;
      if (!xmem_cen) begin
        if (exp_xa.size() == 0) fail_evt("xmem_read");
        else chk("xmem_a", DW'(xmem_a), DW'(exp_xa.pop_front()));
      end
      if (ofifo_rd) begin
        n_pop++;
        chk("pop_only_when_valid", DW'(ofifo_valid), DW'(1'b1));
      end
      pop_pend = ofifo_rd;
      if (!pmem_cen && pmem_wen) begin
        n_pr++;
        if (exp_pr.size() == 0) fail_evt("pmem_read");
        else chk("pmem_rd_a", DW'(pmem_a), DW'(exp_pr.pop_front()));
        rd_pend = 1'b1;
        rd_a    = pmem_a;
      end
      if (!pmem_cen && !pmem_wen) begin
        if (exp_pw.size() == 0) fail_evt("pmem_write");
        else begin
          e = exp_pw.pop_front();
          chk("pmem_wr_a", DW'(pmem_a), DW'(e.a));
          chk("pmem_wr_d", pmem_d, e.d);
          if (cur_acc) chk("rmw_read_prev_cycle", DW'({prev_rd_valid, prev_rd_a}), DW'({1'b1, e.a}));
        end
        wr_pend = 1'b1;
        wr_a    = pmem_a;
        wr_d    = pmem_d;
      end
      prev_rd_valid = !pmem_cen && pmem_wen;
      prev_rd_a     = pmem_a;
      if (load)    n_load++;
      if (l0_wr)   n_l0++;
      if (execute) n_exec++;
      if (done)    n_done++;
    end
  end

  task automatic check_idle_strobes(input string tag);
    chk({tag, "_cmd_ready"}, DW'(cmd_ready), DW'(1'b1));
    chk({tag, "_busy"},      DW'(busy),      DW'(1'b0));
    chk({tag, "_xmem_cen"},  DW'(xmem_cen),  DW'(1'b1));
    chk({tag, "_pmem_cen"},  DW'(pmem_cen),  DW'(1'b1));
    chk({tag, "_pmem_wen"},  DW'(pmem_wen),  DW'(1'b1));
    chk({tag, "_strobes"},   DW'({l0_wr, load, execute, ofifo_rd, done}), DW'(5'b0));
  endtask

  // Issue one tile; the model queues every expected access before the command is offered.
  task automatic run_cmd(input logic [ADDR_W-1:0] w, input logic [ADDR_W-1:0] x,
                         input logic [ADDR_W-1:0] p, input int len, input bit acc,
                         input int vmode, input bit extra, input bit abort);
    logic [DW-1:0] row, nd;
    logic [ADDR_W-1:0] a;
    pw_t e;
    int n;
    for (int i = 0; i < int'(ROW); i++) exp_xa.push_back(w + ADDR_W'(i));
    for (int i = 0; i < len; i++) exp_xa.push_back(x + ADDR_W'(i));
    for (int k = 0; k < len; k++) begin
      row = rand_row();
      if (force_lane0.size() > 0) row[PSUM_BW-1:0] = force_lane0.pop_front();
      ofq.push_back(row);
      a = p + ADDR_W'(k);
      if (acc) begin
        exp_pr.push_back(a);
        nd = sat_row(ref_mem[a], row);
      end else begin
        nd = row;
      end
      ref_mem[a] = nd;
      e.a = a;
      e.d = nd;
      exp_pw.push_back(e);
    end
    if (extra) ofq.push_back(rand_row());
    n_load = 0; n_l0 = 0; n_exec = 0; n_done = 0; n_pop = 0; n_pr = 0;
    cur_acc = acc;
    valid_mode = vmode;

    n = 0;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_before_issue", DW'(cmd_ready), DW'(1'b1));
    cmd_w_base = w; cmd_x_base = x; cmd_p_base = p;
    cmd_len = LEN_W'(len); cmd_acc = acc; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_w_base = ADDR_W'($urandom); cmd_x_base = ADDR_W'($urandom);
    cmd_p_base = ADDR_W'($urandom); cmd_len = LEN_W'($urandom); cmd_acc = 1'($urandom);

    if (abort) begin
      n = 0;
      while (n_l0 < int'(ROW) + 3 && n < 1000) begin @(posedge clk); #1; n++; end
      chk("abort_reached_x_rd", DW'(execute), DW'(1'b1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_idle_strobes("after_abort");
      exp_xa.delete(); exp_pr.delete(); exp_pw.delete(); ofq.delete();
      @(posedge clk); #1;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = mem[i];
      return;
    end

    n = 0;
    while (n_done == 0 && n < 20000) begin @(posedge clk); #1; n++; end
    chk("done_seen", DW'(n_done != 0), DW'(1'b1));
    chk("ready_after_done", DW'(cmd_ready), DW'(1'b1));
    @(posedge clk); #1;
    chk("done_pulses",  DW'(n_done), DW'(1));
    chk("load_cycles",  DW'(n_load), DW'(COL));
    chk("l0_wr_cycles", DW'(n_l0),   DW'(int'(ROW) + len));
    chk("exec_cycles",  DW'(n_exec), DW'((len == 0) ? 0 : len + 1));
    chk("ofifo_pops",   DW'(n_pop),  DW'(len));
    chk("pmem_reads",   DW'(n_pr),   DW'(acc ? len : 0));
    chk("xmem_left",    DW'(exp_xa.size()), DW'(0));
    chk("pmem_wr_left", DW'(exp_pw.size()), DW'(0));
    ofq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = rand_row();
      ref_mem[i] = mem[i];
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_strobes("reset");
    chk("reset_xmem_a", DW'(xmem_a), DW'(0));
    chk("reset_pmem_a", DW'(pmem_a), DW'(0));
    chk("reset_pmem_d", pmem_d, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Plain overwrite tile, OFIFO always valid.
    run_cmd(11'd0, 11'd16, 11'd100, 4, 1'b0, 0, 1'b0, 1'b0);

    // Accumulate 5 + 7.
    mem[100][PSUM_BW-1:0] = 16'd5;
    ref_mem[100] = mem[100];
    force_lane0.push_back(16'd7);
    run_cmd(11'd8, 11'd40, 11'd100, 1, 1'b1, 0, 1'b1, 1'b0);
    chk("acc_5_plus_7", DW'(mem[100][PSUM_BW-1:0]), DW'(16'd12));

    // Saturation at both ends.
    mem[100][PSUM_BW-1:0] = 16'h7FF8;
    mem[101][PSUM_BW-1:0] = 16'h8008;
    ref_mem[100] = mem[100];
    ref_mem[101] = mem[101];
    force_lane0.push_back(16'h0064);
    force_lane0.push_back(16'hFF9C);
    run_cmd(11'd20, 11'd60, 11'd100, 2, 1'b1, 0, 1'b0, 1'b0);
    chk("sat_pos", DW'(mem[100][PSUM_BW-1:0]), DW'(16'h7FFF));
    chk("sat_neg", DW'(mem[101][PSUM_BW-1:0]), DW'(16'h8000));

    // Empty tile with a row waiting and weight addresses wrapping.
    run_cmd(11'd2044, 11'd5, 11'd7, 0, 1'b1, 0, 1'b1, 1'b0);

    // Toggling OFIFO valid and activation address wrap.
    run_cmd(11'd3, 11'd2046, 11'd2045, 4, 1'b0, 1, 1'b1, 1'b0);

    // Abort mid-stream, then a clean tile.
    run_cmd(11'd200, 11'd300, 11'd400, 20, 1'b0, 0, 1'b0, 1'b1);
    run_cmd(11'd210, 11'd310, 11'd410, 5, 1'b1, 2, 1'b1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_cmd(ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
              int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 2,
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
